// File: rtl/hash_pkg.sv
// Shared types and helpers for the hash core front end: opcodes, padder states,
// byte swapping and the partial-word delimiter rule.
package hash_pkg;

  typedef enum logic [1:0] {
    OP_MD5    = 2'b00,
    OP_SHA1   = 2'b01,
    OP_SHA256 = 2'b10
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_LEN,
    ST_FIN
  } pad_state_t;

  localparam int BLOCK_WORDS = 16;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Big-endian word holding the last rem message bytes followed by 0x80.
  function automatic logic [31:0] delimiter(input logic [31:0] bw, input logic [1:0] rem);
    logic [31:0] d;
    d = 32'h8000_0000;
    case (rem)
      2'd1:    d = (bw & 32'hFF00_0000) | 32'h0080_0000;
      2'd2:    d = (bw & 32'hFFFF_0000) | 32'h0000_8000;
      2'd3:    d = (bw & 32'hFFFF_FF00) | 32'h0000_0080;
      default: d = 32'h8000_0000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hash_pad_outreg.sv
// Single valid/ready register slice holding one padded word and its block flags.
module hash_pad_outreg (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_last_word,
  input  logic        i_last_block,
  input  logic        i_ready,
  output logic        o_can_load,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last_word,
  output logic        o_last_block
);

  logic        r_valid;
  logic [31:0] r_data;
  logic        r_last_word;
  logic        r_last_block;

  // Payload only changes on a load, so it stays stable while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_data       <= 32'h0;
      r_last_word  <= 1'b0;
      r_last_block <= 1'b0;
    end else if (i_load) begin
      r_valid      <= 1'b1;
      r_data       <= i_data;
      r_last_word  <= i_last_word;
      r_last_block <= i_last_block;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_can_load   = !r_valid || i_ready;
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_last_word  = r_last_word;
  assign o_last_block = r_last_block;

endmodule

// File: rtl/hash_msg_padder.sv
// Streaming message padder: turns raw 32-bit memory words into complete
// 16-word hash blocks (data, delimiter, zero fill, 64-bit bit length).
module hash_msg_padder
  import hash_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  opcode,
  input  logic [31:0] size,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last_word,
  output logic        out_last_block,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  pad_state_t  r_state, w_state_next;
  logic [31:0] r_widx, r_total, r_nfull;
  logic [1:0]  r_rem;
  logic [34:0] r_bitlen;
  logic        r_md5, r_done;

  logic        w_can_load, w_load, w_last_word, w_last_block;
  logic [31:0] w_word, w_be, w_bw, w_start_nfull, w_start_total, w_widx_inc;

  // The state that owns a given word index: consuming data, fill, or length.
  function automatic pad_state_t classify(input logic [31:0] idx, input logic [31:0] nfull,
                                          input logic [31:0] total, input logic [1:0] rem);
    if (idx >= total - 32'd2) return ST_LEN;
    if (idx < nfull || (idx == nfull && rem != 2'd0)) return ST_DATA;
    return ST_PAD;
  endfunction

  assign w_bw          = bswap32(in_data);
  assign w_start_nfull = {2'b00, size[31:2]};
  assign w_start_total = (((size + 32'd8) >> 6) + 32'd1) << 4;
  assign w_widx_inc    = r_widx + 32'd1;
  assign w_last_word   = (r_widx[3:0] == 4'(BLOCK_WORDS - 1));
  assign w_last_block  = (r_widx >= r_total - 32'(BLOCK_WORDS));

  // Word generation and next state; a word is produced only when the slice can take it.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_be         = 32'h0;
    w_word       = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_done)
          w_state_next = classify(32'd0, w_start_nfull, w_start_total, size[1:0]);
      end
      ST_DATA: begin
        if (in_valid && w_can_load) begin
          w_load       = 1'b1;
          w_be         = (r_widx == r_nfull) ? delimiter(w_bw, r_rem) : w_bw;
          w_word       = r_md5 ? bswap32(w_be) : w_be;
          w_state_next = classify(w_widx_inc, r_nfull, r_total, r_rem);
        end
      end
      ST_PAD: begin
        if (w_can_load) begin
          w_load       = 1'b1;
          w_be         = (r_widx == r_nfull) ? 32'h8000_0000 : 32'h0;
          w_word       = r_md5 ? bswap32(w_be) : w_be;
          w_state_next = classify(w_widx_inc, r_nfull, r_total, r_rem);
        end
      end
      ST_LEN: begin
        if (w_can_load) begin
          w_load = 1'b1;
          if (r_widx == r_total - 32'd1) begin
            w_word       = r_md5 ? {29'b0, r_bitlen[34:32]} : r_bitlen[31:0];
            w_state_next = ST_FIN;
          end else begin
            w_word = r_md5 ? r_bitlen[31:0] : {29'b0, r_bitlen[34:32]};
          end
        end
      end
      ST_FIN: begin
        if (out_valid && out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Message parameters are latched when leaving IDLE; done follows the final transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_widx   <= 32'h0;
      r_total  <= 32'h0;
      r_nfull  <= 32'h0;
      r_rem    <= 2'b00;
      r_bitlen <= 35'h0;
      r_md5    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == ST_FIN) && out_valid && out_ready;
      if (r_state == ST_IDLE && w_state_next != ST_IDLE) begin
        r_widx   <= 32'h0;
        r_nfull  <= w_start_nfull;
        r_rem    <= size[1:0];
        r_total  <= w_start_total;
        r_bitlen <= {size, 3'b000};
        r_md5    <= (opcode == OP_MD5);
      end else if (w_load) begin
        r_widx <= w_widx_inc;
      end
    end
  end

  hash_pad_outreg u_outreg (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_data       (w_word),
    .i_last_word  (w_last_word),
    .i_last_block (w_last_block),
    .i_ready      (out_ready),
    .o_can_load   (w_can_load),
    .o_valid      (out_valid),
    .o_data       (out_data),
    .o_last_word  (out_last_word),
    .o_last_block (out_last_block)
  );

  assign in_ready = (r_state == ST_DATA) && w_can_load;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_hash_msg_padder.sv
// Self-checking bench for hash_msg_padder against a byte-level padding model
// with randomized valid/ready handshakes.
module tb_hash_msg_padder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  opcode;
   logic [31:0] size;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last_word;
   logic        out_last_block;
   logic        out_ready;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] inWords  [256];
   logic [31:0] expWords [256];
   logic [31:0] obsWords [256];
   logic [7:0]  padBytes [1024];

   hash_msg_padder dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .opcode         (opcode),
      .size           (size),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_last_word  (out_last_word),
      .out_last_block (out_last_block),
      .out_ready      (out_ready),
      .busy           (busy),
      .done           (done)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model: classic byte-oriented padding, then packed per endianness.
   task automatic buildExpected(input int sz, input bit md5, output int nw);
      int len;
      logic [63:0] bl;
      for (int i = 0; i < sz; i++) padBytes[i] = inWords[i / 4][8 * (i % 4) +: 8];
      padBytes[sz] = 8'h80;
      len = sz + 1;
      while (len % 64 != 56) begin
         padBytes[len] = 8'h00;
         len++;
      end
      bl = 64'(sz) * 64'd8;
      for (int k = 0; k < 8; k++)
         padBytes[len + k] = md5 ? bl[8 * k +: 8] : bl[8 * (7 - k) +: 8];
      len += 8;
      nw = len / 4;
      for (int w = 0; w < nw; w++) begin
         if (md5) expWords[w] = {padBytes[4*w+3], padBytes[4*w+2], padBytes[4*w+1], padBytes[4*w]};
         else     expWords[w] = {padBytes[4*w], padBytes[4*w+1], padBytes[4*w+2], padBytes[4*w+3]};
      end
   endtask

   task automatic fillRandom();
      for (int i = 0; i < 256; i++) inWords[i] = $urandom;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"},  {31'b0, in_ready},       32'd0);
      checkOutput({tag, "_out_valid"}, {31'b0, out_valid},      32'd0);
      checkOutput({tag, "_out_data"},  out_data,                32'd0);
      checkOutput({tag, "_last_word"}, {31'b0, out_last_word},  32'd0);
      checkOutput({tag, "_last_blk"},  {31'b0, out_last_block}, 32'd0);
      checkOutput({tag, "_busy"},      {31'b0, busy},           32'd0);
      checkOutput({tag, "_done"},      {31'b0, done},           32'd0);
   endtask

   // mode 0: random out_ready, mode 1: always ready, mode 2: 5-cycle stall on word0.
   // abortAt >= 0 returns right after that many words have been handed over.
   task automatic applyStimulus(input int sz, input logic [1:0] op, input int mode, input int abortAt);
      int nin, expTotal, idx, ptr, cyc, limit, firstValid, firstAccept, stallCnt;
      bit lastSent, finished;
      nin = (sz + 3) / 4;
      buildExpected(sz, op == 2'b00, expTotal);
      idx = 0; ptr = 0; cyc = 0; stallCnt = 0;
      firstValid = -1; firstAccept = -1;
      lastSent = 1'b0; finished = 1'b0;
      limit = 200 + expTotal * 12;

      @(negedge clk);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);
      start = 1'b1; opcode = op; size = 32'(sz);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;

      while (!finished && cyc < limit) begin
         cyc++;
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = (ptr < nin) ? inWords[ptr] : $urandom;
         case (mode)
            1: out_ready = 1'b1;
            2: begin
               if (out_valid && idx == 0 && stallCnt < 5) begin
                  out_ready = 1'b0;
                  stallCnt++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         #1;
         if (lastSent) begin
            checkOutput("done_pulse", {31'b0, done}, 32'd1);
            checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
            finished = 1'b1;
         end else begin
            checkOutput("done_early", {31'b0, done}, 32'd0);
            if (out_valid && firstValid < 0) firstValid = cyc;
            if (out_valid && !out_ready) checkOutput("in_ready_stall", {31'b0, in_ready}, 32'd0);
            if (out_valid && idx < expTotal) begin
               checkOutput($sformatf("word%0d", idx), out_data, expWords[idx]);
               checkOutput($sformatf("last_word%0d", idx), {31'b0, out_last_word}, {31'b0, (idx % 16 == 15)});
               checkOutput($sformatf("last_blk%0d", idx), {31'b0, out_last_block}, {31'b0, (idx >= expTotal - 16)});
            end else if (out_valid) begin
               checkOutput("extra_word", {31'b0, out_valid}, 32'd0);
            end
            if (out_valid && out_ready && idx < expTotal) begin
               obsWords[idx] = out_data;
               idx++;
               if (idx == expTotal) lastSent = 1'b1;
            end
            if (in_valid && in_ready) begin
               if (firstAccept < 0) firstAccept = cyc;
               ptr++;
            end
            if (abortAt >= 0 && idx == abortAt) break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      if (abortAt < 0) begin
         if (!finished) checkOutput("timeout_words", 32'(idx), 32'(expTotal));
         checkOutput("inputs_used", 32'(ptr), 32'(nin));
         if (nin == 0) checkOutput("latency_zero", 32'(firstValid), 32'd2);
         else          checkOutput("latency_data", 32'(firstValid - firstAccept), 32'd1);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; opcode = 2'b00; size = 32'd0;
      in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
      fillRandom();
      #12;
      checkResetOutputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Empty message, SHA-256.
      applyStimulus(0, 2'b10, 0, -1);
      checkOutput("zero_w0", obsWords[0], 32'h8000_0000);
      checkOutput("zero_w15", obsWords[15], 32'h0000_0000);

      // "abc" in SHA-1 and MD5 byte orders.
      inWords[0] = 32'h0063_6261;
      applyStimulus(3, 2'b01, 0, -1);
      checkOutput("abc_sha_w0", obsWords[0], 32'h6162_6380);
      checkOutput("abc_sha_w15", obsWords[15], 32'h0000_0018);
      applyStimulus(3, 2'b00, 0, -1);
      checkOutput("abc_md5_w0", obsWords[0], 32'h8063_6261);
      checkOutput("abc_md5_w14", obsWords[14], 32'h0000_0018);
      checkOutput("abc_md5_w15", obsWords[15], 32'h0000_0000);

      // 56 bytes spills the length into a second block.
      fillRandom();
      applyStimulus(56, 2'b10, 0, -1);
      checkOutput("s56_w14", obsWords[14], 32'h8000_0000);
      checkOutput("s56_w31", obsWords[31], 32'h0000_01C0);

      // Downstream stall right after the first word.
      applyStimulus(8, 2'b01, 2, -1);

      // Block-boundary sizes in every mode.
      foreach (inWords[i]) inWords[i] = $urandom;
      for (int s = 52; s <= 65; s++) applyStimulus(s, 2'(s % 4), 0, -1);
      applyStimulus(119, 2'b00, 1, -1);
      applyStimulus(120, 2'b10, 1, -1);

      // Random messages.
      for (int n = 0; n < 20; n++) begin
         fillRandom();
         applyStimulus($urandom_range(0, 200), 2'($urandom_range(0, 3)), 0, -1);
      end

      // Reset in the middle of a 3-block message, then a fresh 4-byte message.
      fillRandom();
      applyStimulus(150, 2'b01, 1, 7);
      reset = 1'b1;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(4, 2'b10, 0, -1);
      applyStimulus(4, 2'b00, 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
